btle_rx_pdu_capture: RTL and testbench

Receive-side stage directly downstream of the access-address correlator. On the correlator's `hit_flag` it captures the following PHY bits as a BLE link-layer packet: it dewhitens each bit, assembles LSB-first octets, extracts the payload length from header octet 1, runs CRC-24 over header and payload, and compares the result against the received 24-bit CRC. Dewhitened octets and a CRC verdict are passed to the downstream PDU consumer.

---
 rtl/btle_rx_pkg.sv | 33 +++
 rtl/btle_crc24_whiten_core.sv | 41 ++++
 rtl/btle_rx_pdu_capture.sv | 127 ++++++++++++
 tb/tb_btle_rx_pdu_capture.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btle_rx_pkg.sv
// Shared types, constants and bit-step helpers for the BLE receive PDU path.
package btle_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    CRC,
    DONE
  } state_t;

  localparam logic [23:0] CRC_POLY    = 24'h00065B;
  localparam int          HEADER_BITS = 16;
  localparam int          CRC_BITS    = 24;

  // x^7+x^4+1: the outgoing w[6] is folded back into w[0] and w[4].
  localparam logic [6:0]  WHITEN_TAPS = 7'b0010001;

  function automatic logic [6:0] whiten_seed(input logic [5:0] channel);
    return {channel[0], channel[1], channel[2], channel[3], channel[4], channel[5], 1'b1};
  endfunction

  function automatic logic [6:0] whiten_step(input logic [6:0] w);
    return {w[5:0], 1'b0} ^ (w[6] ? WHITEN_TAPS : 7'd0);
  endfunction

  function automatic logic [23:0] crc_step(input logic [23:0] c, input logic d);
    logic fb;
    fb = c[23] ^ d;
    return {c[22:0], fb} ^ (fb ? CRC_POLY : 24'd0);
  endfunction

endpackage

// File: rtl/btle_crc24_whiten_core.sv
// Whitening LFSR plus CRC-24 register; a load in the same cycle as a step
// processes that bit from the freshly seeded state.
module btle_crc24_whiten_core
  import btle_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        crc_en,
  input  logic [5:0]  seed_channel,
  input  logic [23:0] seed_crc,
  input  logic        din,
  output logic        dout,
  output logic [23:0] crc
);

  logic [6:0]  whiten;
  logic [6:0]  whiten_cur;
  logic [23:0] crc_reg;
  logic [23:0] crc_cur;

  assign whiten_cur = load ? whiten_seed(seed_channel) : whiten;
  assign crc_cur    = load ? seed_crc : crc_reg;
  assign dout       = din ^ whiten_cur[6];
  assign crc        = crc_cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      whiten  <= '0;
      crc_reg <= '0;
    end else if (step) begin
      whiten  <= whiten_step(whiten_cur);
      crc_reg <= crc_en ? crc_step(crc_cur, dout) : crc_cur;
    end else if (load) begin
      whiten  <= whiten_cur;
      crc_reg <= crc_cur;
    end
  end

endmodule

// File: rtl/btle_rx_pdu_capture.sv
// BLE link-layer PDU capture: dewhitens bits after an access-address hit,
// emits header/payload octets and checks the trailing CRC-24.
module btle_rx_pdu_capture
  import btle_rx_pkg::*;
#(
  parameter int MAX_PAYLOAD_LEN = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phy_bit,
  input  logic        bit_valid,
  input  logic        hit_flag,
  input  logic [5:0]  channel_number,
  input  logic [23:0] crc_state_init_bit,
  output logic [7:0]  octet,
  output logic        octet_valid,
  output logic [7:0]  payload_length,
  output logic        busy,
  output logic        packet_done,
  output logic        crc_ok
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD_LEN);

  state_t      state;
  state_t      next_state;
  state_t      phase;
  logic        accept;
  logic        bit_en;
  logic        d;
  logic [23:0] crc;
  logic [10:0] bit_cnt;
  logic [10:0] cnt_cur;
  logic [7:0]  shift_reg;
  logic [7:0]  assembled;
  logic [7:0]  len_clamped;
  logic        crc_err;
  logic        crc_bit_bad;
  logic        last_header;
  logic        last_payload;
  logic        last_crc;

  // A hit in IDLE behaves as if HEADER bit 0 were already current.
  assign accept       = (state == IDLE) && hit_flag;
  assign phase        = accept ? HEADER : state;
  assign cnt_cur      = accept ? '0 : bit_cnt;
  assign bit_en       = bit_valid && (phase == HEADER || phase == PAYLOAD || phase == CRC);
  assign assembled    = {d, shift_reg[7:1]};
  assign len_clamped  = (assembled > MAX_LEN) ? MAX_LEN : assembled;
  assign last_header  = (phase == HEADER)  && (cnt_cur == 11'(HEADER_BITS - 1));
  assign last_payload = (phase == PAYLOAD) && (cnt_cur == {payload_length, 3'b000} - 11'd1);
  assign last_crc     = (phase == CRC)     && (cnt_cur == 11'(CRC_BITS - 1));
  assign crc_bit_bad  = d != crc[5'd23 - cnt_cur[4:0]];

  btle_crc24_whiten_core u_core (
    .clk          (clk),
    .rst          (rst),
    .load         (accept),
    .step         (bit_en),
    .crc_en       (phase != CRC),
    .seed_channel (channel_number),
    .seed_crc     (crc_state_init_bit),
    .din          (phy_bit),
    .dout         (d),
    .crc          (crc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (hit_flag) next_state = HEADER;
      HEADER:  if (bit_en && last_header) next_state = (len_clamped == 8'd0) ? CRC : PAYLOAD;
      PAYLOAD: if (bit_en && last_payload) next_state = CRC;
      CRC:     if (bit_en && last_crc) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt        <= '0;
      shift_reg      <= '0;
      octet          <= '0;
      octet_valid    <= 1'b0;
      payload_length <= '0;
      busy           <= 1'b0;
      packet_done    <= 1'b0;
      crc_ok         <= 1'b0;
      crc_err        <= 1'b0;
    end else begin
      octet_valid <= 1'b0;
      packet_done <= 1'b0;
      busy        <= (next_state != IDLE);
      if (accept) begin
        crc_ok  <= 1'b0;
        crc_err <= 1'b0;
      end
      if (bit_en) begin
        bit_cnt <= (next_state != phase) ? '0 : cnt_cur + 11'd1;
        if (phase == CRC) begin
          if (last_crc) begin
            packet_done <= 1'b1;
            crc_ok      <= !(crc_err || crc_bit_bad);
          end else begin
            crc_err <= crc_err || crc_bit_bad;
          end
        end else begin
          shift_reg <= assembled;
          if (cnt_cur[2:0] == 3'd7) begin
            octet       <= assembled;
            octet_valid <= 1'b1;
          end
          if (last_header) payload_length <= len_clamped;
        end
      end else if (accept) begin
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_btle_rx_pdu_capture.sv
// Scenario bench for btle_rx_pdu_capture: expected octets go through a
// scoreboard queue, timing and CRC verdicts are checked per scenario.
module tb_btle_rx_pdu_capture;

  localparam int MAX_LEN = 37;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        phy_bit = 1'b0;
  logic        bit_valid = 1'b0;
  logic        hit_flag = 1'b0;
  logic [5:0]  channel_number = '0;
  logic [23:0] crc_state_init_bit = '0;
  logic [7:0]  octet;
  logic        octet_valid;
  logic [7:0]  payload_length;
  logic        busy;
  logic        packet_done;
  logic        crc_ok;

  int          cycle = 0;
  int          checks = 0;
  int          failures = 0;
  int          done_count = 0;
  int          done_cycle = 0;
  int          hit_cycle = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_oct;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  btle_rx_pdu_capture #(.MAX_PAYLOAD_LEN(MAX_LEN)) dut (
    .clk                (clk),
    .rst                (rst),
    .phy_bit            (phy_bit),
    .bit_valid          (bit_valid),
    .hit_flag           (hit_flag),
    .channel_number     (channel_number),
    .crc_state_init_bit (crc_state_init_bit),
    .octet              (octet),
    .octet_valid        (octet_valid),
    .payload_length     (payload_length),
    .busy               (busy),
    .packet_done        (packet_done),
    .crc_ok             (crc_ok)
  );

  // Scoreboard side: every octet strobe must match the oldest pushed octet.
  always @(negedge clk) begin
    if (octet_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL octet_unexpected: got %02h, required no octet", octet);
      end else begin
        exp_oct = exp_q.pop_front();
        if (octet !== exp_oct) begin
          failures++;
          $display("[TB] FAIL octet_value: got %02h, required %02h", octet, exp_oct);
        end
      end
    end
    if (packet_done === 1'b1) begin
      done_count++;
      done_cycle = cycle;
    end
  end

  function automatic logic [6:0] m_wh_init(input logic [5:0] ch);
    logic [6:0] w;
    w[0] = 1'b1;
    for (int k = 1; k < 7; k++) w[k] = ch[6-k];
    return w;
  endfunction

  function automatic logic [6:0] m_wh_next(input logic [6:0] w);
    logic [6:0] n;
    n[0] = w[6];
    n[1] = w[0];
    n[2] = w[1];
    n[3] = w[2];
    n[4] = w[3] ^ w[6];
    n[5] = w[4];
    n[6] = w[5];
    return n;
  endfunction

  function automatic logic [23:0] m_crc_next(input logic [23:0] c, input logic d);
    logic        fb;
    logic [23:0] n;
    fb = c[23] ^ d;
    n  = {c[22:0], fb};
    if (fb) n = n ^ 24'h00065B;
    return n;
  endfunction

  task automatic drive_packet(input logic [5:0] ch, input logic [23:0] preset,
                              input logic [7:0] pdu[$], input int flip_bit,
                              input bit bad_crc, input int gap,
                              input int hit_at_bit, input int abort_at_bit);
    logic [23:0] c;
    logic [6:0]  w;
    logic [7:0]  tx[$];
    logic [7:0]  t;
    logic        d;
    int          pdu_bits;
    c = preset;
    foreach (pdu[i]) begin
      t = pdu[i];
      for (int j = 0; j < 8; j++) c = m_crc_next(c, t[j]);
    end
    if (bad_crc) c = ~c;
    tx = pdu;
    if (flip_bit >= 0) begin
      t = tx[flip_bit/8];
      t[flip_bit%8] = ~t[flip_bit%8];
      tx[flip_bit/8] = t;
    end
    pdu_bits = tx.size() * 8;
    channel_number     = ch;
    crc_state_init_bit = preset;
    w = m_wh_init(ch);
    for (int i = 0; i < pdu_bits + 24; i++) begin
      @(negedge clk);
      if (i < pdu_bits) begin
        t = tx[i/8];
        d = t[i%8];
      end else begin
        d = c[23-(i-pdu_bits)];
      end
      phy_bit   = d ^ w[6];
      w         = m_wh_next(w);
      bit_valid = 1'b1;
      hit_flag  = (i == 0);
      if (i == 0) hit_cycle = cycle;
      if (i == abort_at_bit) begin
        rst = 1'b1;
        return;
      end
      if (i < pdu_bits && (i % 8) == 7) exp_q.push_back(tx[i/8]);
      for (int g = 1; g < gap; g++) begin
        @(negedge clk);
        bit_valid = 1'b0;
        phy_bit   = ~phy_bit;
        hit_flag  = (i == hit_at_bit && g == 3);
      end
    end
    @(negedge clk);
    bit_valid = 1'b0;
    hit_flag  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_count < target && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic void adv_pdu(output logic [7:0] q[$]);
    q = '{8'h40, 8'h06, 8'hD6, 8'hBE, 8'h89, 8'h8E, 8'h12, 8'h34};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({octet, octet_valid, payload_length, busy, packet_done, crc_ok} !== 20'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %05h, required 00000",
               {octet, octet_valid, payload_length, busy, packet_done, crc_ok});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle_busy: got %b, required 0", busy);
    end
  endtask

  task automatic run_and_check(input string name, input logic [5:0] ch,
                               input logic [7:0] pdu[$], input int flip_bit,
                               input bit bad_crc, input int gap, input int hit_at_bit,
                               input int exp_delay, input logic [7:0] exp_len,
                               input logic exp_ok);
    int start = done_count;
    drive_packet(ch, 24'h555555, pdu, flip_bit, bad_crc, gap, hit_at_bit, -1);
    wait_done(start + 1);
    checks++;
    if (done_count !== start + 1) begin
      failures++;
      $display("[TB] FAIL %s_done_count: got %0d, required %0d", name, done_count - start, 1);
    end
    checks++;
    if (done_cycle - hit_cycle !== exp_delay) begin
      failures++;
      $display("[TB] FAIL %s_done_delay: got %0d, required %0d", name, done_cycle - hit_cycle, exp_delay);
    end
    checks++;
    if (crc_ok !== exp_ok) begin
      failures++;
      $display("[TB] FAIL %s_crc_ok: got %b, required %b", name, crc_ok, exp_ok);
    end
    checks++;
    if (payload_length !== exp_len) begin
      failures++;
      $display("[TB] FAIL %s_payload_length: got %0d, required %0d", name, payload_length, exp_len);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_drain: got %0d pending octets busy=%b, required 0 pending busy=0",
               name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic test_adv_packet();
    logic [7:0] q[$];
    adv_pdu(q);
    run_and_check("adv", 6'd37, q, -1, 1'b0, 1, -1, 88, 8'd6, 1'b1);
  endtask

  task automatic test_crc_error();
    logic [7:0] q[$];
    adv_pdu(q);
    run_and_check("crc_err", 6'd37, q, 16 + 13, 1'b0, 1, -1, 88, 8'd6, 1'b0);
  endtask

  task automatic test_zero_length();
    logic [7:0] q[$];
    q = '{8'h46, 8'h00};
    run_and_check("zero_len", 6'd38, q, -1, 1'b0, 1, -1, 40, 8'd0, 1'b1);
  endtask

  task automatic test_oversampled();
    logic [7:0] q[$];
    adv_pdu(q);
    run_and_check("oversampled", 6'd37, q, -1, 1'b0, 8, 30, 8 * 87 + 1, 8'd6, 1'b1);
  endtask

  task automatic test_reset_abort();
    logic [7:0] q[$];
    int start;
    adv_pdu(q);
    start = done_count;
    drive_packet(6'd37, 24'h555555, q, -1, 1'b0, 1, -1, 16 + 24 + 3);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_busy_before: got %b, required 1", busy);
    end
    @(negedge clk);
    checks++;
    if ({octet, octet_valid, payload_length, busy, packet_done, crc_ok} !== 20'd0) begin
      failures++;
      $display("[TB] FAIL abort_outputs: got %05h, required 00000",
               {octet, octet_valid, payload_length, busy, packet_done, crc_ok});
    end
    rst = 1'b0;
    bit_valid = 1'b0;
    hit_flag = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (done_count !== start || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL abort_no_done: got %0d dones %0d pending, required 0 dones 0 pending",
               done_count - start, exp_q.size());
      exp_q.delete();
    end
    run_and_check("after_abort", 6'd37, q, -1, 1'b0, 1, -1, 88, 8'd6, 1'b1);
  endtask

  task automatic test_clamp();
    logic [7:0] q[$];
    q = '{8'h42, 8'd200};
    for (int i = 0; i < MAX_LEN; i++) q.push_back(8'(i * 7 + 3));
    run_and_check("clamp", 6'd12, q, -1, 1'b1, 1, -1, 40 + 8 * MAX_LEN, 8'(MAX_LEN), 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int start = done_count;
    adv_pdu(q1);
    q2 = '{8'h46, 8'h00};
    drive_packet(6'd37, 24'h555555, q1, -1, 1'b0, 1, -1, -1);
    drive_packet(6'd38, 24'h555555, q2, -1, 1'b0, 1, -1, -1);
    wait_done(start + 2);
    checks++;
    if (done_count !== start + 2) begin
      failures++;
      $display("[TB] FAIL b2b_done_count: got %0d, required 2", done_count - start);
    end
    checks++;
    if (done_cycle - hit_cycle !== 40 || crc_ok !== 1'b1 || payload_length !== 8'd0) begin
      failures++;
      $display("[TB] FAIL b2b_second: got delay %0d crc_ok %b len %0d, required delay 40 crc_ok 1 len 0",
               done_cycle - hit_cycle, crc_ok, payload_length);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL b2b_drain: got %0d pending octets, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: got no completion, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_adv_packet();
    test_crc_error();
    test_zero_length();
    test_oversampled();
    test_reset_abort();
    test_clamp();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
